// File: rtl/fp_addsub_normalize_shift0.sv
// Coarse normaliser for the FP add/sub path: lz count, 0/16/32 shift, exp adjust.
// Optional stats counters enabled by defining FP_NORM_STATS_EN.
module fp_addsub_normalize_shift0 #(
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [32:0]      in_mant,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32:0]      out_mant,
    output logic [3:0]       out_shift,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_uflow
`ifdef FP_NORM_STATS_EN
    ,
    input  logic             stat_clr,
    output logic [15:0]      stat_zero_cnt,
    output logic [15:0]      stat_uflow_cnt
`endif
);

    localparam int CW = EXP_W + 6;

    logic             r_s1_valid;
    logic [32:0]      r_s1_mant;
    logic [EXP_W-1:0] r_s1_exp;
    logic [5:0]       r_s1_lz;

    logic             r_s2_valid;
    logic [32:0]      r_mant;
    logic [3:0]       r_shift;
    logic [EXP_W-1:0] r_exp;
    logic             r_zero;
    logic             r_uflow;

    logic             w_s2_load;
    logic             w_s1_load;
    logic [5:0]       w_lz;
    logic [5:0]       w_cs;
    logic             w_zero;
    logic             w_uflow;
    logic [CW-1:0]    w_lz_x;
    logic [CW-1:0]    w_exp_x;
    logic [CW-1:0]    w_diff;
    logic [32:0]      w_mant;
    logic [3:0]       w_shift;
    logic [EXP_W-1:0] w_exp;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_s1_load = in_valid && in_ready;

    // Highest set bit wins: later iterations overwrite lower ones.
    always_comb begin
        w_lz = 6'd33;
        for (int i = 0; i < 33; i++) begin
            if (in_mant[i]) w_lz = 6'(32 - i);
        end
    end

    always_comb begin
        w_cs    = {r_s1_lz[5:4], 4'b0000};
        w_zero  = (r_s1_lz == 6'd33);
        w_lz_x  = CW'(r_s1_lz);
        w_exp_x = CW'(r_s1_exp);
        w_diff  = w_exp_x - w_lz_x;
        w_uflow = !w_zero && (w_lz_x > w_exp_x);
        w_mant  = w_zero ? 33'd0 : (r_s1_mant << w_cs);
        w_shift = w_zero ? 4'd0 : r_s1_lz[3:0];
        w_exp   = (w_zero || w_uflow) ? '0 : w_diff[EXP_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_mant  <= '0;
            r_s1_exp   <= '0;
            r_s1_lz    <= '0;
        end else begin
            if (in_ready) r_s1_valid <= in_valid;
            if (w_s1_load) begin
                r_s1_mant <= in_mant;
                r_s1_exp  <= in_exp;
                r_s1_lz   <= w_lz;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_mant     <= '0;
            r_shift    <= '0;
            r_exp      <= '0;
            r_zero     <= 1'b0;
            r_uflow    <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_mant  <= w_mant;
                r_shift <= w_shift;
                r_exp   <= w_exp;
                r_zero  <= w_zero;
                r_uflow <= w_uflow;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_mant  = r_mant;
    assign out_shift = r_shift;
    assign out_exp   = r_exp;
    assign out_zero  = r_zero;
    assign out_uflow = r_uflow;

`ifdef FP_NORM_STATS_EN
    logic        w_xfer;
    logic [15:0] r_zero_cnt;
    logic [15:0] r_uflow_cnt;

    assign w_xfer = r_s2_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            r_zero_cnt  <= '0;
            r_uflow_cnt <= '0;
        end else begin
            if (w_xfer && r_zero && r_zero_cnt != 16'hFFFF)
                r_zero_cnt <= r_zero_cnt + 16'd1;
            if (w_xfer && r_uflow && r_uflow_cnt != 16'hFFFF)
                r_uflow_cnt <= r_uflow_cnt + 16'd1;
        end
    end

    assign stat_zero_cnt  = r_zero_cnt;
    assign stat_uflow_cnt = r_uflow_cnt;
`endif

endmodule

// File: tb/tb_fp_addsub_normalize_shift0.sv
// Bench for fp_addsub_normalize_shift0: vector table, stall/reset sequences,
// random traffic against a queue-based reference model.
module tb_fp_addsub_normalize_shift0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] in_mant;
    logic [7:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] out_mant;
    logic [3:0]  out_shift;
    logic [7:0]  out_exp;
    logic        out_zero;
    logic        out_uflow;
`ifdef FP_NORM_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_zero_cnt;
    logic [15:0] stat_uflow_cnt;
`endif

    always #5 clk = ~clk;

    fp_addsub_normalize_shift0 #(.EXP_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_shift (out_shift),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_uflow (out_uflow)
`ifdef FP_NORM_STATS_EN
        ,
        .stat_clr       (stat_clr),
        .stat_zero_cnt  (stat_zero_cnt),
        .stat_uflow_cnt (stat_uflow_cnt)
`endif
    );

    typedef struct {
        logic [32:0] mant;
        logic [3:0]  sh;
        logic [7:0]  ex;
        logic        z;
        logic        u;
    } res_t;

    typedef struct {
        logic [32:0] mant;
        logic [7:0]  exp;
        res_t        r;
    } vec_t;

    int nchk = 0;
    int nerr = 0;
    int n_out = 0;
    res_t q[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    // Reference: count zeros from the MSB, split into 16-multiples and remainder.
    function automatic res_t model(input logic [32:0] m, input logic [7:0] e);
        res_t r;
        int n = 0;
        while (n < 33 && !m[32-n]) n++;
        if (n == 33) begin
            r.mant = 0; r.sh = 0; r.ex = 0; r.z = 1; r.u = 0;
        end else begin
            r.mant = m << ((n / 16) * 16);
            r.sh   = 4'(n % 16);
            r.z    = 0;
            r.u    = (n > int'(e));
            r.ex   = r.u ? 8'd0 : 8'(int'(e) - n);
        end
        return r;
    endfunction

    res_t held;
    logic hold = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_mant", 64'(out_mant), 64'(held.mant));
                chk("stall_shift", 64'(out_shift), 64'(held.sh));
                chk("stall_exp", 64'(out_exp), 64'(held.ex));
            end
            hold = out_valid && !out_ready;
            held.mant = out_mant; held.sh = out_shift; held.ex = out_exp;
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    res_t e;
                    e = q.pop_front();
                    chk("sb_mant", 64'(out_mant), 64'(e.mant));
                    chk("sb_shift", 64'(out_shift), 64'(e.sh));
                    chk("sb_exp", 64'(out_exp), 64'(e.ex));
                    chk("sb_zero", 64'(out_zero), 64'(e.z));
                    chk("sb_uflow", 64'(out_uflow), 64'(e.u));
                    if (out_mant != 0)
                        chk("sb_normal", 64'((out_mant << out_shift) >> 32), 64'd1);
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_mant, in_exp));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && k < 50) begin
            tick();
            k++;
        end
        chk("drain_timeout", 64'(k < 50), 64'd1);
    endtask

    vec_t tbl[10];
    logic [32:0] beats[6];

    initial begin
        int n0;
        int idx;
        logic [63:0] rnd;
        logic took;
        int sent;

        tbl[0] = '{33'h1_0000_0000, 8'd100, '{33'h1_0000_0000, 4'd0, 8'd100, 1'b0, 1'b0}};
        tbl[1] = '{33'h0_0000_8000, 8'd50,  '{33'h0_8000_0000, 4'd1, 8'd33, 1'b0, 1'b0}};
        tbl[2] = '{33'h0_0000_0001, 8'd10,  '{33'h1_0000_0000, 4'd0, 8'd0, 1'b0, 1'b1}};
        tbl[3] = '{33'h0,           8'd77,  '{33'h0, 4'd0, 8'd0, 1'b1, 1'b0}};
        tbl[4] = '{33'h0_0000_8000, 8'd17,  '{33'h0_8000_0000, 4'd1, 8'd0, 1'b0, 1'b0}};
        tbl[5] = '{33'h0_0000_8000, 8'd16,  '{33'h0_8000_0000, 4'd1, 8'd0, 1'b0, 1'b1}};
        tbl[6] = '{33'h0_0002_0000, 8'd200, '{33'h0_0002_0000, 4'd15, 8'd185, 1'b0, 1'b0}};
        tbl[7] = '{33'h0_0001_0000, 8'd16,  '{33'h1_0000_0000, 4'd0, 8'd0, 1'b0, 1'b0}};
        tbl[8] = '{33'h0,           8'd0,   '{33'h0, 4'd0, 8'd0, 1'b1, 1'b0}};
        tbl[9] = '{33'h1_FFFF_FFFF, 8'd0,   '{33'h1_FFFF_FFFF, 4'd0, 8'd0, 1'b0, 1'b0}};

        rst_n = 1'b0; in_valid = 1'b0; in_mant = '0; in_exp = '0; out_ready = 1'b1;
`ifdef FP_NORM_STATS_EN
        stat_clr = 1'b0;
`endif
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_mant", 64'(out_mant), 64'd0);
        chk("rst_out_shift", 64'(out_shift), 64'd0);
        chk("rst_out_exp", 64'(out_exp), 64'd0);
        chk("rst_out_zero", 64'(out_zero), 64'd0);
        chk("rst_out_uflow", 64'(out_uflow), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        foreach (tbl[i]) begin
            in_valid = 1'b1; in_mant = tbl[i].mant; in_exp = tbl[i].exp;
            tick();
            in_valid = 1'b0;
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_mant", i), 64'(out_mant), 64'(tbl[i].r.mant));
            chk($sformatf("vec%0d_shift", i), 64'(out_shift), 64'(tbl[i].r.sh));
            chk($sformatf("vec%0d_exp", i), 64'(out_exp), 64'(tbl[i].r.ex));
            chk($sformatf("vec%0d_zero", i), 64'(out_zero), 64'(tbl[i].r.z));
            chk($sformatf("vec%0d_uflow", i), 64'(out_uflow), 64'(tbl[i].r.u));
        end
        tick();
        drain();

        // Six back-to-back beats with the sink stalled for cycles 3..5.
        for (int i = 0; i < 6; i++) beats[i] = 33'h1_0000_0000 >> (i * 5);
        n0 = n_out; idx = 0;
        for (int c = 0; c < 30 && idx < 6; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            in_valid = 1'b1; in_mant = beats[idx]; in_exp = 8'(40 + idx);
            @(negedge clk);
            if (c == 4) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_out_valid", 64'(out_valid), 64'd1);
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();
        chk("stall_beats_out", 64'(n_out - n0), 64'd6);

        // Reset with two beats in flight.
        n0 = n_out;
        out_ready = 1'b0;
        in_valid = 1'b1; in_mant = 33'h0_0000_00FF; in_exp = 8'd60;
        tick();
        in_mant = 33'h0_00FF_0000;
        tick();
        in_valid = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 4; k++) tick();
        chk("flush_no_beats", 64'(n_out - n0), 64'd0);

        // Random traffic with random backpressure.
        sent = 0; took = 1'b0; in_valid = 1'b0;
        while (sent < 400) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || took) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rnd = {$urandom(), $urandom()};
                in_mant = rnd[32:0] >> $urandom_range(0, 33);
                if ($urandom_range(0, 15) == 0) in_mant = '0;
                in_exp = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) sent++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

`ifdef FP_NORM_STATS_EN
        stat_clr = 1'b1; tick(); stat_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_mant = '0; in_exp = 8'(i + 5);
            tick();
        end
        in_valid = 1'b0;
        drain();
        chk("stat_zero_cnt", 64'(stat_zero_cnt), 64'd3);
        stat_clr = 1'b1; tick(); stat_clr = 1'b0;
        chk("stat_zero_clr", 64'(stat_zero_cnt), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
